// File: rtl/mem_stage_sram.sv
// rtl/mem_stage_sram.sv - MEM pipeline stage with handshaked external SRAM access and timeout
// Optional macro MEM_ADDR_OFFSET_EN rebases data addresses so byte 1024 maps to word 0.
module mem_stage_sram #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  writeBackEnIn,
    input  logic                  memReadIn,
    input  logic                  memWriteIn,
    input  logic [31:0]           ALUResultIn,
    input  logic [31:0]           storeValIn,
    input  logic [3:0]            destinationIn,
    output logic                  freeze,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [31:0]           memWData,
    input  logic [31:0]           memRData,
    input  logic                  memAck,
    output logic                  writeBackEn,
    output logic                  memRead,
    output logic [31:0]           ALUResult,
    output logic [31:0]           memData,
    output logic [3:0]            destination,
    output logic                  busErr
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_is_write;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic [31:0]           r_rdata;
    logic                  r_bus_err;
    logic                  r_wb_en;
    logic                  r_mem_read;
    logic [31:0]           r_alu_result;
    logic [31:0]           r_mem_data;
    logic [3:0]            r_dest;

    logic                  w_mem_op;
    logic                  w_timeout;
    logic                  w_freeze;
    logic                  w_mem_req;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_word_addr;

    assign w_mem_op  = memReadIn | memWriteIn;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MEM_ADDR_OFFSET_EN
    // Byte offset 1024 is exactly 256 words, so subtracting after word selection is equivalent.
    assign w_word_addr = ALUResultIn[ADDR_WIDTH+1:2] - ADDR_WIDTH'(256);
`else
    assign w_word_addr = ALUResultIn[ADDR_WIDTH+1:2];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_mem_op) w_state_nxt = S_REQ;
            S_REQ:   if (memAck || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_freeze  = 1'b0;
        w_mem_req = 1'b0;
        w_mem_we  = 1'b0;
        case (r_state)
            S_IDLE: w_freeze = w_mem_op;
            S_REQ: begin
                w_freeze  = 1'b1;
                w_mem_req = 1'b1;
                w_mem_we  = r_is_write;
            end
            default: ;
        endcase
    end

    // Access bookkeeping: request latch on entry, ack/timeout capture in REQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_is_write  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        r_cnt       <= '0;
                        r_is_write  <= memWriteIn;
                        r_mem_addr  <= w_word_addr;
                        r_mem_wdata <= storeValIn;
                    end
                end
                S_REQ: begin
                    if (memAck) begin
                        r_rdata <= r_is_write ? 32'h0 : memRData;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_timeout) begin
                            r_rdata   <= 32'h0;
                            r_bus_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // MEM-to-WB register: bubble while frozen, captured data only when leaving DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_en      <= 1'b0;
            r_mem_read   <= 1'b0;
            r_alu_result <= '0;
            r_mem_data   <= '0;
            r_dest       <= '0;
        end else if (w_freeze) begin
            r_wb_en    <= 1'b0;
            r_mem_read <= 1'b0;
        end else begin
            r_wb_en      <= writeBackEnIn;
            r_mem_read   <= memReadIn & ~memWriteIn;
            r_alu_result <= ALUResultIn;
            r_dest       <= destinationIn;
            if (r_state == S_DONE) r_mem_data <= r_rdata;
        end
    end

    assign freeze      = w_freeze & rst;
    assign memReq      = w_mem_req;
    assign memWe       = w_mem_we;
    assign memAddr     = r_mem_addr;
    assign memWData    = r_mem_wdata;
    assign busErr      = r_bus_err;
    assign writeBackEn = r_wb_en;
    assign memRead     = r_mem_read;
    assign ALUResult   = r_alu_result;
    assign memData     = r_mem_data;
    assign destination = r_dest;

endmodule

// File: tb/tb_mem_stage_sram.sv
// tb/tb_mem_stage_sram.sv - directed self-checking bench for mem_stage_sram
module tb_mem_stage_sram;
    logic        clk = 1'b0;
    logic        rst;
    logic        writeBackEnIn, memReadIn, memWriteIn;
    logic [31:0] ALUResultIn, storeValIn;
    logic [3:0]  destinationIn;
    logic        freeze, memReq, memWe;
    logic [15:0] memAddr;
    logic [31:0] memWData, memRData;
    logic        memAck;
    logic        writeBackEn, memRead;
    logic [31:0] ALUResult, memData;
    logic [3:0]  destination;
    logic        busErr;

    int n_chk  = 0;
    int n_pass = 0;
    int n_req;
    logic [31:0] exp_load_addr, exp_store_addr;

    mem_stage_sram #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst(rst),
        .writeBackEnIn(writeBackEnIn), .memReadIn(memReadIn), .memWriteIn(memWriteIn),
        .ALUResultIn(ALUResultIn), .storeValIn(storeValIn), .destinationIn(destinationIn),
        .freeze(freeze), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memWData(memWData), .memRData(memRData), .memAck(memAck),
        .writeBackEn(writeBackEn), .memRead(memRead), .ALUResult(ALUResult),
        .memData(memData), .destination(destination), .busErr(busErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic wb, input logic rd, input logic wr,
                         input logic [31:0] alu, input logic [31:0] sv, input logic [3:0] dst);
        writeBackEnIn = wb; memReadIn = rd; memWriteIn = wr;
        ALUResultIn = alu; storeValIn = sv; destinationIn = dst;
    endtask

    initial begin
`ifdef MEM_ADDR_OFFSET_EN
        exp_load_addr  = 32'h0002;
        exp_store_addr = 32'hFF04;
`else
        exp_load_addr  = 32'h0102;
        exp_store_addr = 32'h0004;
`endif
        rst = 1'b0; memAck = 1'b0; memRData = 32'h0;
        drive(1'b1, 1'b1, 1'b0, 32'h408, 32'h0, 4'd1);
        #3;
        check("rst_freeze", {31'h0, freeze}, 32'h0);
        check("rst_memReq", {31'h0, memReq}, 32'h0);
        check("rst_wb", {31'h0, writeBackEn}, 32'h0);
        check("rst_busErr", {31'h0, busErr}, 32'h0);
        check("rst_memAddr", {16'h0, memAddr}, 32'h0);
        step;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        step;
        rst = 1'b1;
        step;

        // ALU ops: one-cycle latency, no freeze
        drive(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3);
        #1 check("alu1_freeze", {31'h0, freeze}, 32'h0);
        step;
        check("alu1_wb", {31'h0, writeBackEn}, 32'h1);
        check("alu1_dest", {28'h0, destination}, 32'h3);
        check("alu1_res", ALUResult, 32'h55);
        drive(1'b1, 1'b0, 1'b0, 32'hA5A5, 32'h0, 4'd7);
        step;
        check("alu2_res", ALUResult, 32'hA5A5);
        check("alu2_dest", {28'h0, destination}, 32'h7);

        // Load at 0x408, ack in first REQ cycle
        drive(1'b1, 1'b1, 1'b0, 32'h408, 32'h0, 4'd5);
        #1 check("ld_freeze_c0", {31'h0, freeze}, 32'h1);
        check("ld_req_c0", {31'h0, memReq}, 32'h0);
        step;
        memAck = 1'b1; memRData = 32'hCAFEF00D;
        #1 check("ld_req_c1", {31'h0, memReq}, 32'h1);
        check("ld_we_c1", {31'h0, memWe}, 32'h0);
        check("ld_addr", {16'h0, memAddr}, exp_load_addr);
        check("ld_freeze_c1", {31'h0, freeze}, 32'h1);
        check("ld_bubble_wb", {31'h0, writeBackEn}, 32'h0);
        check("ld_bubble_res", ALUResult, 32'hA5A5);
        step;
        memAck = 1'b0;
        #1 check("ld_freeze_c2", {31'h0, freeze}, 32'h0);
        check("ld_req_c2", {31'h0, memReq}, 32'h0);
        step;
        check("ld_memRead", {31'h0, memRead}, 32'h1);
        check("ld_data", memData, 32'hCAFEF00D);
        check("ld_wb", {31'h0, writeBackEn}, 32'h1);
        check("ld_dest", {28'h0, destination}, 32'h5);
        drive(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 4'd9);
        #1 check("alu3_freeze", {31'h0, freeze}, 32'h0);
        step;
        check("alu3_hold_data", memData, 32'hCAFEF00D);
        check("alu3_res", ALUResult, 32'h77);
        check("alu3_memRead", {31'h0, memRead}, 32'h0);

        // Store at 0x10 with read also set (treated as write), ack in 4th REQ cycle
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h12345678, 4'd0);
        #1 check("st_freeze_c0", {31'h0, freeze}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step;
            check("st_req", {31'h0, memReq}, 32'h1);
            check("st_we", {31'h0, memWe}, 32'h1);
            check("st_addr", {16'h0, memAddr}, exp_store_addr);
            check("st_wdata", memWData, 32'h12345678);
            check("st_bubble_wb", {31'h0, writeBackEn}, 32'h0);
        end
        step;
        memAck = 1'b1;
        #1 check("st_req_c4", {31'h0, memReq}, 32'h1);
        check("st_wdata_c4", memWData, 32'h12345678);
        step;
        memAck = 1'b0;
        #1 check("st_done_freeze", {31'h0, freeze}, 32'h0);
        step;
        check("st_memData", memData, 32'h0);
        check("st_memRead", {31'h0, memRead}, 32'h0);
        check("st_busErr", {31'h0, busErr}, 32'h0);

        // Load with no ack: timeout after 15 REQ cycles
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'd2);
        step;
        n_req = 0;
        while (memReq && n_req < 40) begin
            n_req++;
            step;
        end
        check("to_req_cycles", n_req, 32'd15);
        check("to_busErr", {31'h0, busErr}, 32'h1);
        check("to_done_freeze", {31'h0, freeze}, 32'h0);
        step;
        check("to_memData", memData, 32'h0);
        check("to_memRead", {31'h0, memRead}, 32'h1);
        drive(1'b1, 1'b0, 1'b0, 32'h99, 32'h0, 4'd4);
        step;
        check("to_busErr_sticky", {31'h0, busErr}, 32'h1);

        // Reset during REQ aborts the access
        drive(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 4'd6);
        step;
        check("rr_req_before", {31'h0, memReq}, 32'h1);
        #1 rst = 1'b0;
        #1 check("rr_req", {31'h0, memReq}, 32'h0);
        check("rr_freeze", {31'h0, freeze}, 32'h0);
        check("rr_res", ALUResult, 32'h0);
        check("rr_busErr", {31'h0, busErr}, 32'h0);
        check("rr_addr", {16'h0, memAddr}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        memAck = 1'b1; memRData = 32'hDEADBEEF;
        step;
        rst = 1'b1;
        step;
        check("rr_stray_req", {31'h0, memReq}, 32'h0);
        check("rr_stray_freeze", {31'h0, freeze}, 32'h0);
        check("rr_stray_data", memData, 32'h0);
        step;
        check("rr_stray_req2", {31'h0, memReq}, 32'h0);
        check("rr_stray_memRead", {31'h0, memRead}, 32'h0);
        memAck = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_stage_sram.md
MEM_STAGE_SRAM -- requirements
Module: mem_stage_sram

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, word-address width driven to external memory.
REQ-002 Parameter TIMEOUT_CYCLES, default 15, maximum REQ-state cycles waited for memAck.
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 Ports writeBackEnIn, memReadIn, memWriteIn  input  1 each  control from EXE-to-MEM register.
REQ-006 Port ALUResultIn  input  32  byte address for memory ops, result otherwise.
REQ-007 Port storeValIn  input  32  store data.
REQ-008 Port destinationIn  input  4  destination register index.
REQ-009 Port freeze  output  1  stalls all upstream stages and pipeline registers while high.
REQ-010 Ports memReq, memWe  output  1 each  external request and write strobe.
REQ-011 Port memAddr  output  ADDR_WIDTH  word address; port memWData  output  32  write data.
REQ-012 Ports memRData  input  32 and memAck  input  1  read data and completion from external memory.
REQ-013 Ports writeBackEn, memRead  output  1 each; ALUResult, memData  output  32 each; destination  output  4: registered MEM-to-WB outputs.
REQ-014 Port busErr  output  1  sticky timeout flag.

Function
REQ-015 FSM states IDLE, REQ, DONE; encoding free.
REQ-016 IDLE with memReadIn=memWriteIn=0: freeze=0; outputs load inputs at the next edge (1-cycle latency); memData holds its previous value.
REQ-017 IDLE with memReadIn or memWriteIn=1: freeze=1 combinationally; next state REQ; counter cleared.
REQ-018 memReadIn and memWriteIn both 1: treated as a write; memRead output forced 0.
REQ-019 REQ: memReq=1; memWe=1 for writes; memAddr and memWData are registered on IDLE-to-REQ entry and held stable until exit; freeze=1.
REQ-020 memAck is sampled only in REQ and ignored in all other states.
REQ-021 REQ with memAck=1: read data is captured from memRData; next state DONE.
REQ-022 REQ without memAck: counter increments; when counter reaches TIMEOUT_CYCLES-1, next state is DONE, captured read data is 0x00000000, and busErr is set.
REQ-023 DONE: memReq=0, freeze=0; outputs load at the edge ending DONE (memData = captured data, or 0 for writes); next state IDLE.
REQ-024 While freeze=1, the output register loads a bubble: writeBackEn=0, memRead=0, other outputs unchanged.
REQ-025 With an ack in the first REQ cycle, freeze is high for exactly 2 cycles and the result appears 3 cycles after the op is first presented.
REQ-026 memAddr = ALUResultIn[ADDR_WIDTH+1:2]; the two low address bits are ignored.
REQ-027 busErr is sticky and clears only on reset.

Reset
REQ-028 rst low immediately forces IDLE, clears the counter, and sets memReq=memWe=0, busErr=0, and all registered outputs, memAddr and memWData to 0.
REQ-029 Reset asserted during REQ aborts the access; the aborted op is not retried after reset release.
REQ-030 freeze is 0 while rst is low.

Configuration
REQ-031 Macro MEM_ADDR_OFFSET_EN defined: memAddr is derived from (ALUResultIn - 32'd1024) before word selection, mapping data space base 1024 to word 0.
REQ-032 Macro MEM_ADDR_OFFSET_EN undefined: memAddr is derived from ALUResultIn directly, per REQ-026.
REQ-033 The ALUResult output always carries the untranslated ALUResultIn.

Verification
REQ-034 ALU op (writeBackEnIn=1, destinationIn=3, ALUResultIn=0x55) -> next cycle writeBackEn=1, destination=3, ALUResult=0x55, freeze stays 0.
REQ-035 Load at address 0x408 with MEM_ADDR_OFFSET_EN defined; ack in first REQ cycle with memRData=0xCAFEF00D -> memAddr=2, freeze high 2 cycles, then memRead=1, memData=0xCAFEF00D.
REQ-036 Store storeValIn=0x12345678 at address 0x10 with macro undefined; ack after 3 cycles -> memWe=1, memAddr=4, memWData=0x12345678 stable throughout; writeBackEn bubble=0 while frozen.
REQ-037 Load with memAck never asserted, TIMEOUT_CYCLES=15 -> exit after 15 REQ cycles, memData=0, busErr=1 and it stays 1 on later ops.
REQ-038 rst pulsed low during REQ -> memReq and freeze drop immediately, all outputs 0; a stray memAck after release causes no state change.
